float_to_fixed_e4m3: RTL

FLOAT_TO_FIXED_E4M3 -- requirements
Module: float_to_fixed_e4m3

---
 rtl/float_pkg.sv | 31 +++
 rtl/e4m3_unpack.sv | 27 ++
 rtl/float_to_fixed_e4m3.sv | 94 +++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared E4M3 field layout, fixed-point format and FSM state encoding for the
// E4M3-to-fixed converter.
package float_pkg;

  localparam int E4M3_W        = 8;
  localparam int E4M3_SIGN_POS = 7;
  localparam int E4M3_EXP_LSB  = 3;
  localparam int E4M3_EXP_W    = 4;
  localparam int E4M3_MAN_LSB  = 0;
  localparam int E4M3_MAN_W    = 3;
  localparam int E4M3_BIAS     = 7;

  localparam logic [E4M3_EXP_W-1:0] E4M3_NAN_EXP = 4'hF;
  localparam logic [E4M3_MAN_W-1:0] E4M3_NAN_MAN = 3'h7;

  localparam int FIXED_FRAC = 9;

  localparam int SIG_W = E4M3_MAN_W + 1;
  localparam int CNT_W = 4;
  localparam int MAG_W = 18;

  // {1,man} carries 3 fraction bits, so the fixed-point shift is exp - bias + (9 - 3).
  localparam logic [CNT_W-1:0] SHIFT_ADJ = CNT_W'(FIXED_FRAC - E4M3_MAN_W - E4M3_BIAS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/e4m3_unpack.sv
// Combinational E4M3 field decode: sign, significand with hidden bit,
// left-shift amount into the 9-fraction-bit fixed-point grid, and NaN flag.
module e4m3_unpack
  import float_pkg::*;
(
  input  logic [E4M3_W-1:0] i_data,
  output logic              o_sign,
  output logic [SIG_W-1:0]  o_sig,
  output logic [CNT_W-1:0]  o_shift,
  output logic              o_is_nan
);

  logic [E4M3_EXP_W-1:0] w_exp;
  logic [E4M3_MAN_W-1:0] w_man;
  logic                  w_normal;

  assign w_exp    = i_data[E4M3_EXP_LSB +: E4M3_EXP_W];
  assign w_man    = i_data[E4M3_MAN_LSB +: E4M3_MAN_W];
  assign w_normal = (w_exp != '0);

  assign o_sign   = i_data[E4M3_SIGN_POS];
  assign o_sig    = {w_normal, w_man};
  // Subnormals already sit at LSB = 2^-9, so they take no shift.
  assign o_shift  = w_normal ? (w_exp + SHIFT_ADJ) : '0;
  assign o_is_nan = (w_exp == E4M3_NAN_EXP) && (w_man == E4M3_NAN_MAN);

endmodule

// File: rtl/float_to_fixed_e4m3.sv
// E4M3 to two's-complement fixed-point (9 fraction bits), shifting the
// significand one bit per cycle with a valid/ready handshake on each side.
//
// state    | meaning
// ST_IDLE  | waiting for an operand, in_ready = 1
// ST_SHIFT | shifting mag left until cnt reaches 0, then register the result
// ST_DONE  | result presented, held until out_ready
module float_to_fixed_e4m3
  import float_pkg::*;
#(
  parameter int OUT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_nan
);

  state_t             r_state;
  logic [MAG_W-1:0]   r_mag;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_nan;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_nan;

  logic               w_sign;
  logic [SIG_W-1:0]   w_sig;
  logic [CNT_W-1:0]   w_shift;
  logic               w_nan;
  logic [OUT_W-1:0]   w_mag_ext;
  logic [OUT_W-1:0]   w_result;

  e4m3_unpack u_unpack (
    .i_data   (in_data),
    .o_sign   (w_sign),
    .o_sig    (w_sig),
    .o_shift  (w_shift),
    .o_is_nan (w_nan)
  );

  assign w_mag_ext = {{(OUT_W-MAG_W){1'b0}}, r_mag};
  // Negating zero yields zero, so -0 needs no special case.
  assign w_result  = r_nan ? '0 : (r_sign ? -w_mag_ext : w_mag_ext);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_nan      <= 1'b0;
      r_out_data <= '0;
      r_out_nan  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mag   <= {{(MAG_W-SIG_W){1'b0}}, w_sig};
            r_cnt   <= w_shift;
            r_sign  <= w_sign;
            r_nan   <= w_nan;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_out_data <= w_result;
            r_out_nan  <= r_nan;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_out_data;
  assign out_nan   = r_out_nan;

endmodule
